// File: rtl/nv_csa_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nv_csa_accum_pkg
// Description : Shared FSM encoding and width-parameterised helpers for
//               nv_csa_accum.
// Revision    : 1.0 - initial release
// ============================================================================
package nv_csa_accum_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } acc_state_e;

   // Helpers work on a 64-bit carrier; callers size-cast to their own width.
   function automatic logic [63:0] sext64(input logic [63:0] val, input int unsigned width);
      logic signed [63:0] w_t;
      w_t = $signed(val << (64 - width));
      return w_t >>> (64 - width);
   endfunction

   function automatic logic [63:0] smax64(input int unsigned width);
      return (64'd1 << (width - 1)) - 64'd1;
   endfunction

   function automatic logic [63:0] smin64(input int unsigned width);
      return ~smax64(width);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nv_csa_cpa.sv
`default_nettype none
// ============================================================================
// Module      : nv_csa_cpa
// Description : Stage-1 carry-propagate add of the CSA sum/carry pair with a
//               single-entry s1 register and its ready/valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module nv_csa_cpa #(
   parameter int IN_WIDTH = 8
) (
   input  logic                nvdla_core_clk,
   input  logic                nvdla_core_rstn,
   input  logic                in_pvld,
   output logic                in_prdy,
   input  logic [IN_WIDTH-1:0] in_sum,
   input  logic [IN_WIDTH-1:0] in_carry,
   input  logic                s2_accept,
   output logic                s1_vld,
   output logic [IN_WIDTH-1:0] s1_data
);

   logic                r_s1_vld;
   logic [IN_WIDTH-1:0] r_s1_data;
   logic [IN_WIDTH-1:0] w_cpa;

   // Carry out of the MSB is dropped: the tree result is defined mod 2^IN_WIDTH.
   assign w_cpa   = in_sum + in_carry;
   assign in_prdy = !r_s1_vld || s2_accept;
   assign s1_vld  = r_s1_vld;
   assign s1_data = r_s1_data;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_s1_vld  <= 1'b0;
         r_s1_data <= '0;
      end else if (in_prdy) begin
         r_s1_vld <= in_pvld;
         if (in_pvld) begin
            r_s1_data <= w_cpa;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/nv_csa_accum.sv
`default_nettype none
// ============================================================================
// Module      : nv_csa_accum
// Description : Resolves CSA beats and accumulates cfg_len+1 beats per group
//               into a signed result on a valid/ready output.
//               Optional saturation: define NV_CSA_ACCUM_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nv_csa_accum
   import nv_csa_accum_pkg::*;
#(
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 24,
   parameter int LEN_WIDTH = 8
) (
   input  logic                 nvdla_core_clk,
   input  logic                 nvdla_core_rstn,
   input  logic [LEN_WIDTH-1:0] cfg_len,
   input  logic                 in_pvld,
   output logic                 in_prdy,
   input  logic [IN_WIDTH-1:0]  in_sum,
   input  logic [IN_WIDTH-1:0]  in_carry,
   output logic                 out_pvld,
   input  logic                 out_prdy,
   output logic [ACC_WIDTH-1:0] out_data,
   output logic                 out_sat
);

   logic                 w_s1_vld;
   logic [IN_WIDTH-1:0]  w_s1_data;
   logic                 w_accept;
   logic                 w_last;
   logic                 w_load_out;

   acc_state_e           r_state, w_state_nxt;
   logic [LEN_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [LEN_WIDTH-1:0] r_len_q, w_len_nxt;
   logic [ACC_WIDTH-1:0] r_acc, w_acc_nxt;
   logic [ACC_WIDTH-1:0] r_out_data, w_out_data_nxt;
   logic                 r_out_pvld, w_out_pvld_nxt;
   logic [ACC_WIDTH-1:0] w_ext;
   logic [ACC_WIDTH-1:0] w_base;
   logic [ACC_WIDTH-1:0] w_sum;

   nv_csa_cpa #(
      .IN_WIDTH (IN_WIDTH)
   ) u_cpa (
      .nvdla_core_clk  (nvdla_core_clk),
      .nvdla_core_rstn (nvdla_core_rstn),
      .in_pvld         (in_pvld),
      .in_prdy         (in_prdy),
      .in_sum          (in_sum),
      .in_carry        (in_carry),
      .s2_accept       (w_accept),
      .s1_vld          (w_s1_vld),
      .s1_data         (w_s1_data)
   );

   assign w_ext    = ACC_WIDTH'(sext64(64'(w_s1_data), IN_WIDTH));
   assign w_base   = (r_state == ST_IDLE) ? '0 : r_acc;
   assign w_last   = (r_state == ST_IDLE) ? (cfg_len == '0) : (r_cnt == r_len_q);
   // Only a group-closing beat needs the output register; others never stall.
   assign w_accept = w_s1_vld && !(w_last && r_out_pvld && !out_prdy);

`ifdef NV_CSA_ACCUM_SAT_EN
   localparam logic [ACC_WIDTH-1:0] c_sat_max = ACC_WIDTH'(smax64(ACC_WIDTH));
   localparam logic [ACC_WIDTH-1:0] c_sat_min = ACC_WIDTH'(smin64(ACC_WIDTH));

   logic [ACC_WIDTH:0] w_wide;
   logic               w_ovf;
   logic               w_grp_sat;
   logic               r_grp_sat;
   logic               r_out_sat;

   assign w_wide    = {w_base[ACC_WIDTH-1], w_base} + {w_ext[ACC_WIDTH-1], w_ext};
   assign w_ovf     = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];
   assign w_sum     = !w_ovf ? w_wide[ACC_WIDTH-1:0] :
                      (w_wide[ACC_WIDTH] ? c_sat_min : c_sat_max);
   assign w_grp_sat = ((r_state == ST_ACC) && r_grp_sat) || w_ovf;
   assign out_sat   = r_out_sat;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_grp_sat <= 1'b0;
         r_out_sat <= 1'b0;
      end else begin
         if (w_accept) begin
            r_grp_sat <= w_grp_sat;
         end
         if (w_load_out) begin
            r_out_sat <= w_grp_sat;
         end
      end
   end
`else
   assign w_sum   = w_base + w_ext;
   assign out_sat = 1'b0;
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_len_nxt      = r_len_q;
      w_acc_nxt      = r_acc;
      w_out_data_nxt = r_out_data;
      w_out_pvld_nxt = r_out_pvld && !out_prdy;
      w_load_out     = 1'b0;
      if (w_accept) begin
         if (r_state == ST_IDLE) begin
            w_len_nxt = cfg_len;
         end
         w_acc_nxt = w_sum;
         if (w_last) begin
            w_state_nxt    = ST_IDLE;
            w_cnt_nxt      = '0;
            w_out_data_nxt = w_sum;
            w_out_pvld_nxt = 1'b1;
            w_load_out     = 1'b1;
         end else begin
            w_state_nxt = ST_ACC;
            w_cnt_nxt   = r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_len_q    <= '0;
         r_acc      <= '0;
         r_out_data <= '0;
         r_out_pvld <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_len_q    <= w_len_nxt;
         r_acc      <= w_acc_nxt;
         r_out_data <= w_out_data_nxt;
         r_out_pvld <= w_out_pvld_nxt;
      end
   end

   assign out_pvld = r_out_pvld;
   assign out_data = r_out_data;

endmodule
`default_nettype wire

// File: doc/nv_csa_accum.md
# nv_csa_accum

Final-stage consumer of the carry-save adder tree. Takes the redundant sum/carry pair produced for each dot-product beat and resolves it with a carry-propagate addition. It then accumulates a programmable number of beats into a wide signed result and returns it through a valid/ready output. It sits directly downstream of the CSA tree in the MAC datapath and is fully pipelined at one beat per cycle.

## Interface
- IN_WIDTH, 8: width of each carry-save operand; equals the tree's operand width.
- ACC_WIDTH, 24: accumulator and result width; must be at least IN_WIDTH.
- LEN_WIDTH, 8: width of the beat-count configuration.

- nvdla_core_clk  input  1  core clock; all state updates on the rising edge.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- cfg_len  input  LEN_WIDTH  beats per group minus one; 0 means 1 beat.
- in_pvld  input  1  input beat valid.
- in_prdy  output  1  input beat ready.
- in_sum  input  IN_WIDTH  partial-sum vector from the tree.
- in_carry  input  IN_WIDTH  shifted-carry vector from the tree.
- out_pvld  output  1  result valid.
- out_prdy  input  1  result ready.
- out_data  output  ACC_WIDTH  accumulated signed result.
- out_sat  output  1  saturation occurred in this group; constant 0 when saturation is compiled out.

## Operation
- Input handshake: a beat transfers on in_pvld && in_prdy. Output handshake: a result transfers on out_pvld && out_prdy. A valid, once asserted, holds its data stable until the transfer.
- Stage 1 (CPA):
  - cpa = (in_sum + in_carry) mod 2^IN_WIDTH, interpreted as two's complement and sign-extended to ACC_WIDTH.
  - The result is registered into s1_data/s1_vld.
- Stage 2 (accumulate) has a two-state FSM:
  - IDLE: no group is open.
  - ACC: a group is open and beat counter cnt is nonzero.
  - On a stage-2 accept in IDLE, cfg_len is latched into len_q, acc = ext(cpa), and cnt = 1.
  - On a stage-2 accept in ACC, acc = acc + ext(cpa) and cnt increments.
  - The beat is the last beat of its group when cnt == len_q, or when cfg_len == 0 in IDLE. On the last beat the final sum is written to the output register, out_pvld is set, and the FSM returns to IDLE. In that same cycle the accumulator register is not required to hold its value.
  - cfg_len changes during ACC have no effect until the next group.
- Stage-2 accept condition: s1_vld && !(last && out_pvld && !out_prdy). The output register may be refilled in the same cycle it is popped.
- in_prdy = !s1_vld || stage-2 accept. It is combinational from out_prdy and state; there is no path from in_pvld.
- Arithmetic wraps modulo 2^ACC_WIDTH unless saturation is compiled in.
- Reset mid-group discards the partial group. After reset the FSM is in IDLE with cnt = 0.

## Timing
- Reset values: in_prdy = 1 (from s1_vld = 0), out_pvld = 0, out_data = 0, out_sat = 0, FSM = IDLE, cnt = 0, len_q = 0, acc = 0.
- Latency: the last beat transferring in cycle T gives out_pvld high in cycle T+2, provided there is no backpressure.
- Throughput is one beat per cycle sustained. Back-to-back groups with cfg_len = 0 produce one result per cycle.
- Under output backpressure, at most one finished result and one s1 beat are held. in_prdy drops in the cycle stage 2 stalls.

## Configuration
- NV_CSA_ACCUM_SAT_EN defined:
  - Each add saturates to the signed range [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - out_sat is sticky over the group and is presented with out_data. It clears when a new group opens.
- NV_CSA_ACCUM_SAT_EN undefined:
  - Each add wraps modulo 2^ACC_WIDTH.
  - out_sat is tied to 0 and no saturation logic is present.

## Structure
- Shared package nv_csa_accum_pkg holds:
  - the FSM state encoding (IDLE, ACC);
  - the functions for sign extension and signed max/min limits, parameterised by width.
- One sub-module, nv_csa_cpa: the stage-1 carry-propagate add plus its s1 register and skid handshake.
- Stage 2 and the output register live in the top level.

## Test plan
- cfg_len = 0, in_sum = 0x05, in_carry = 0x0A -> out_data = 15 (0x00000F) with out_pvld high two cycles after the transfer.
- cfg_len = 3, four beats each of sum = 0xFF and carry = 0x00 -> exactly one result, out_data = 0xFFFFFC (-4).
- cfg_len = 0, sum = 0x80, carry = 0x80 (CPA overflow) -> out_data = 0. Then sum = 0x7F, carry = 0x01 -> out_data = 0xFFFF80 (-128).
- Stream 10 groups with cfg_len = 0 and out_prdy held low for 5 cycles:
  - in_prdy falls after two results are held;
  - no beat is lost or duplicated;
  - results emerge in order;
  - a new result is accepted in the same cycle as a pop.
- ACC_WIDTH = 10, cfg_len = 4, five beats of 0x7F:
  - with NV_CSA_ACCUM_SAT_EN -> out_data = 511, out_sat = 1;
  - without it -> out_data = 0x27B (wraps to -389), out_sat = 0.
- cfg_len = 3, two beats sent, then nvdla_core_rstn pulsed low -> all outputs return to reset values. The next group, with cfg_len changed to 1 and two beats of value 1, gives out_data = 2.
